// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetches one/two-word instructions from synchronous program memory and sequences execution
`ifndef STATE_HLT
`define STATE_HLT      4'd0
`define STATE_FETCH0   4'd1
`define STATE_FETCH0_W 4'd2
`define STATE_FETCH1   4'd3
`define STATE_FETCH1_W 4'd4
`define STATE_EXEC     4'd5
`endif
`ifndef OP_END
`define OP_LIMM16 8'h10
`define OP_LIMM32 8'h11
`define OP_LBSET  8'h20
`define OP_CND    8'h30
`define OP_END    8'h3F
`endif
module instr_fetch_ctrl #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] pmem_addr,
  input  logic [31:0]     pmem_rdata,
  output logic [31:0]     instr0,
  output logic [31:0]     instr1,
  output logic [3:0]      current_state,
  output logic [PC_W-1:0] pc,
  input  logic            jump_req,
  input  logic [PC_W-1:0] jump_addr,
  input  logic [31:0]     cnd_val,
  input  logic            mmu_invalid,
  output logic            halted,
  output logic            fault
);
  typedef enum logic [3:0] {
    HLT      = `STATE_HLT,
    FETCH0   = `STATE_FETCH0,
    FETCH0_W = `STATE_FETCH0_W,
    FETCH1   = `STATE_FETCH1,
    FETCH1_W = `STATE_FETCH1_W,
    EXEC     = `STATE_EXEC
  } state_t;
  state_t state;
  logic skip, rd_two, ex_two, unused_cnd;
  logic [PC_W-1:0] pc_inc1, pc_next;
  always_comb begin
    rd_two  = pmem_rdata[31:24] == `OP_LIMM32 || pmem_rdata[31:24] == `OP_LBSET;
    ex_two  = instr0[31:24] == `OP_LIMM32 || instr0[31:24] == `OP_LBSET;
    pc_inc1 = pc + PC_W'(1);
    pc_next = pc + (ex_two ? PC_W'(2) : PC_W'(1));
  end
  assign current_state = state;
  assign halted        = state == HLT;
  assign unused_cnd    = ^cnd_val[31:1];
  always_ff @(posedge clk)
    if (reset) begin
      state     <= HLT;
      pc        <= RESET_PC;
      pmem_addr <= RESET_PC;
      instr0    <= '0;
      instr1    <= '0;
      fault     <= 1'b0;
      skip      <= 1'b0;
    end else
      case (state)
        HLT:
          if (run && !fault) begin
            state     <= FETCH0;
            pmem_addr <= pc;
          end
        FETCH0: state <= FETCH0_W;
        FETCH0_W: begin
          instr0 <= pmem_rdata;
          instr1 <= '0;
          if (rd_two) begin
            state     <= FETCH1;
            pmem_addr <= pc_inc1;
          end else if (skip) begin
            skip      <= 1'b0;
            pc        <= pc_inc1;
            pmem_addr <= pc_inc1;
            state     <= FETCH0;
          end else
            state <= EXEC;
        end
        FETCH1: state <= FETCH1_W;
        FETCH1_W: begin
          instr1 <= pmem_rdata;
          if (skip) begin
            skip      <= 1'b0;
            pc        <= pc_next;
            pmem_addr <= pc_next;
            state     <= FETCH0;
          end else
            state <= EXEC;
        end
        EXEC:
          if (mmu_invalid) begin
            fault <= 1'b1;
            state <= HLT;
          end else if (instr0[31:24] == `OP_END)
            state <= HLT;
          else if (jump_req) begin
            pc        <= jump_addr;
            pmem_addr <= jump_addr;
            state     <= FETCH0;
          end else begin
            if (instr0[31:24] == `OP_CND && !cnd_val[0]) skip <= 1'b1;
            pc        <= pc_next;
            pmem_addr <= pc_next;
            state     <= FETCH0;
          end
        default: state <= HLT;
      endcase
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: vector table, directed sequences and model-checked random programs for instr_fetch_ctrl
`ifndef STATE_HLT
`define STATE_HLT      4'd0
`define STATE_FETCH0   4'd1
`define STATE_FETCH0_W 4'd2
`define STATE_FETCH1   4'd3
`define STATE_FETCH1_W 4'd4
`define STATE_EXEC     4'd5
`endif
`ifndef OP_END
`define OP_LIMM16 8'h10
`define OP_LIMM32 8'h11
`define OP_LBSET  8'h20
`define OP_CND    8'h30
`define OP_END    8'h3F
`endif
module tb_instr_fetch_ctrl;
  localparam logic [3:0] S_HLT = `STATE_HLT, S_F0 = `STATE_FETCH0, S_F0W = `STATE_FETCH0_W;
  localparam logic [3:0] S_F1W = `STATE_FETCH1_W, S_EX = `STATE_EXEC;
  localparam logic [7:0] O_L16 = `OP_LIMM16, O_L32 = `OP_LIMM32, O_LB = `OP_LBSET;
  localparam logic [7:0] O_CND = `OP_CND, O_END = `OP_END;
  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0, jump_req = 1'b0, mmu_invalid = 1'b0;
  logic [15:0] jump_addr = '0;
  logic [31:0] cnd_val = 32'h1;
  logic [15:0] pmem_addr, pc;
  logic [31:0] pmem_rdata, instr0, instr1;
  logic [3:0] current_state;
  logic halted, fault;
  logic [31:0] mem [0:65535];
  int checks = 0, failures = 0;
  instr_fetch_ctrl #(.PC_W(16), .RESET_PC(16'h0)) dut (
    .clk(clk), .reset(reset), .run(run), .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata),
    .instr0(instr0), .instr1(instr1), .current_state(current_state), .pc(pc),
    .jump_req(jump_req), .jump_addr(jump_addr), .cnd_val(cnd_val), .mmu_invalid(mmu_invalid),
    .halted(halted), .fault(fault)
  );
  always #5 clk = ~clk;
  always @(posedge clk) pmem_rdata <= mem[pmem_addr];
  typedef struct {
    logic [7:0] op; logic mmu; logic jmp; logic [15:0] ja; logic [31:0] cv;
    int cyc; logic [3:0] st; logic [15:0] npc; logic [15:0] addr; logic flt; logic [31:0] i1;
  } vec_t;
  typedef struct { int cyc; logic [15:0] pc; logic [31:0] i0; logic [31:0] i1; } ex_t;
  vec_t vt [13];
  logic [3:0] seq [7];
  ex_t exp_q [$];
  logic s_j [64];
  logic [15:0] s_ja [64];
  logic [31:0] s_cv [64];
  logic s_mmu [64];
  int m_end_cyc;
  logic [15:0] m_pc;
  logic m_halt, m_fault;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run = 1'b0; jump_req = 1'b0; mmu_invalid = 1'b0; cnd_val = 32'h1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic clear_prog();
    for (int i = 0; i < 64; i++) mem[i] = {O_L16, 8'h0, 16'(i)};
    mem[65535] = {O_L16, 24'hFFFF};
    for (int k = 0; k < 64; k++) begin
      s_j[k] = 1'b0; s_ja[k] = '0; s_cv[k] = 32'h1; s_mmu[k] = 1'b0;
    end
  endtask
  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 15);
    if (r == 0) w[31:24] = O_END;
    else if (r < 4) w[31:24] = O_CND;
    else if (r < 6) w[31:24] = O_L32;
    else if (r < 8) w[31:24] = O_LB;
    else if (w[31:24] inside {O_END, O_CND, O_L32, O_LB}) w[31:24] = O_L16;
    return w;
  endfunction
  task automatic rand_prog();
    for (int i = 0; i < 256; i++) begin
      mem[i] = rand_word();
      mem[32'hFF00 + i] = rand_word();
    end
    for (int k = 0; k < 64; k++) begin
      s_j[k]   = $urandom_range(0, 5) == 0;
      s_ja[k]  = $urandom_range(0, 1) ? 16'($urandom_range(0, 200)) : 16'($urandom_range(16'hFF00, 16'hFFFF));
      s_cv[k]  = $urandom;
      s_mmu[k] = $urandom_range(0, 39) == 0;
    end
  endtask
  // Instruction-level interpreter: each executed instruction costs 3 or 5 cycles, a skipped one 2 or 4.
  task automatic model(input int max_ex);
    logic [15:0] p, p1;
    logic sk, two;
    logic [7:0] op;
    int cyc, k;
    ex_t e;
    exp_q.delete();
    p = 16'h0; sk = 1'b0; cyc = 0; m_halt = 1'b0; m_fault = 1'b0;
    while (exp_q.size() < max_ex) begin
      op = mem[p][31:24];
      two = op == O_L32 || op == O_LB;
      p1 = p + 16'd1;
      if (sk) begin
        sk = 1'b0;
        cyc += two ? 4 : 2;
        p += two ? 16'd2 : 16'd1;
        continue;
      end
      cyc += two ? 5 : 3;
      e.cyc = cyc; e.pc = p; e.i0 = mem[p]; e.i1 = two ? mem[p1] : 32'h0;
      k = exp_q.size();
      exp_q.push_back(e);
      if (s_mmu[k]) begin m_fault = 1'b1; m_halt = 1'b1; break; end
      if (op == O_END) begin m_halt = 1'b1; break; end
      if (s_j[k]) p = s_ja[k];
      else begin
        if (op == O_CND && !s_cv[k][0]) sk = 1'b1;
        p += two ? 16'd2 : 16'd1;
      end
    end
    m_pc = p; m_end_cyc = cyc;
  endtask
  task automatic run_prog(input string tag);
    int k, limit;
    model(40);
    do_reset();
    run = 1'b1;
    k = 0;
    limit = m_end_cyc + 6;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (current_state == S_EX) begin
        if (k < exp_q.size()) begin
          chk($sformatf("%s exec%0d cycle", tag, k), c, exp_q[k].cyc);
          chk($sformatf("%s exec%0d pc", tag, k), pc, exp_q[k].pc);
          chk($sformatf("%s exec%0d instr0", tag, k), instr0, exp_q[k].i0);
          chk($sformatf("%s exec%0d instr1", tag, k), instr1, exp_q[k].i1);
          jump_req = s_j[k]; jump_addr = s_ja[k]; cnd_val = s_cv[k]; mmu_invalid = s_mmu[k];
        end else begin
          checks++; failures++;
          $display("FAIL %s unexpected exec: pc %0h at cycle %0d, expected none", tag, pc, c);
        end
        k++;
      end else begin
        jump_req = 1'($urandom); jump_addr = 16'($urandom);
        cnd_val = $urandom; mmu_invalid = 1'($urandom);
      end
      run = current_state == S_HLT ? m_fault : 1'($urandom);
      if (!m_halt && k == exp_q.size()) break;
    end
    chk($sformatf("%s exec count", tag), k, exp_q.size());
    if (m_halt) begin
      chk($sformatf("%s halted", tag), halted, 1'b1);
      chk($sformatf("%s final pc", tag), pc, m_pc);
      chk($sformatf("%s fault", tag), fault, m_fault);
    end
  endtask
  initial begin
    int c;
    vt[0]  = '{O_L16, 1'b0, 1'b0, 16'h0,    32'h0, 3, S_F0,  16'h1,    16'h1,    1'b0, 32'h0};
    vt[1]  = '{O_L32, 1'b0, 1'b0, 16'h0,    32'h0, 5, S_F0,  16'h2,    16'h2,    1'b0, 32'hDEADBEEF};
    vt[2]  = '{O_LB,  1'b0, 1'b0, 16'h0,    32'h0, 5, S_F0,  16'h2,    16'h2,    1'b0, 32'hDEADBEEF};
    vt[3]  = '{O_END, 1'b0, 1'b0, 16'h0,    32'h0, 3, S_HLT, 16'h0,    16'h0,    1'b0, 32'h0};
    vt[4]  = '{O_L16, 1'b1, 1'b0, 16'h0,    32'h0, 3, S_HLT, 16'h0,    16'h0,    1'b1, 32'h0};
    vt[5]  = '{O_END, 1'b1, 1'b0, 16'h0,    32'h0, 3, S_HLT, 16'h0,    16'h0,    1'b1, 32'h0};
    vt[6]  = '{O_L32, 1'b1, 1'b1, 16'h0100, 32'h0, 5, S_HLT, 16'h0,    16'h1,    1'b1, 32'hDEADBEEF};
    vt[7]  = '{O_END, 1'b0, 1'b1, 16'h0100, 32'h0, 3, S_HLT, 16'h0,    16'h0,    1'b0, 32'h0};
    vt[8]  = '{O_L16, 1'b0, 1'b1, 16'h0100, 32'h0, 3, S_F0,  16'h0100, 16'h0100, 1'b0, 32'h0};
    vt[9]  = '{O_LB,  1'b0, 1'b1, 16'hFFFF, 32'h0, 5, S_F0,  16'hFFFF, 16'hFFFF, 1'b0, 32'hDEADBEEF};
    vt[10] = '{O_CND, 1'b0, 1'b0, 16'h0,    32'h0, 3, S_F0,  16'h1,    16'h1,    1'b0, 32'h0};
    vt[11] = '{O_CND, 1'b0, 1'b1, 16'h0040, 32'h0, 3, S_F0,  16'h0040, 16'h0040, 1'b0, 32'h0};
    vt[12] = '{O_L32, 1'b0, 1'b0, 16'h0,    32'h0, 5, S_F0,  16'h2,    16'h2,    1'b0, 32'hDEADBEEF};
    seq = '{S_F0, S_F0W, S_EX, S_F0, S_F0W, S_EX, S_HLT};
    for (int i = 0; i < 65536; i++) mem[i] = {O_L16, 8'h0, 16'(i)};
    for (int v = 0; v < 13; v++) begin
      mem[0] = {vt[v].op, 24'h00A5C3};
      mem[1] = 32'hDEADBEEF;
      do_reset();
      chk($sformatf("vec%0d reset state", v), current_state, S_HLT);
      chk($sformatf("vec%0d reset pc", v), pc, 16'h0);
      chk($sformatf("vec%0d reset instr0", v), instr0, 32'h0);
      chk($sformatf("vec%0d reset instr1", v), instr1, 32'h0);
      chk($sformatf("vec%0d reset addr", v), pmem_addr, 16'h0);
      chk($sformatf("vec%0d reset fault", v), fault, 1'b0);
      chk($sformatf("vec%0d reset halted", v), halted, 1'b1);
      run = 1'b1;
      c = 0;
      do begin @(negedge clk); c++; end while (current_state != S_EX && c < 12);
      chk($sformatf("vec%0d exec cycle", v), c, vt[v].cyc);
      chk($sformatf("vec%0d instr1", v), instr1, vt[v].i1);
      jump_req = vt[v].jmp; jump_addr = vt[v].ja; cnd_val = vt[v].cv; mmu_invalid = vt[v].mmu;
      run = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d next state", v), current_state, vt[v].st);
      chk($sformatf("vec%0d next pc", v), pc, vt[v].npc);
      chk($sformatf("vec%0d next addr", v), pmem_addr, vt[v].addr);
      chk($sformatf("vec%0d fault", v), fault, vt[v].flt);
      jump_req = 1'b0; mmu_invalid = 1'b0;
    end
    clear_prog();
    mem[1] = {O_END, 24'h0};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("seq state %0d", i), current_state, seq[i]);
    end
    chk("seq end pc", pc, 16'h1);
    chk("seq halted", halted, 1'b1);
    clear_prog();
    mem[1] = {O_L32, 24'h5};
    mem[2] = 32'h12345678;
    do_reset();
    run = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (current_state != S_F1W && c < 20);
    chk("midrst reach FETCH1_W", current_state, S_F1W);
    chk("midrst cycle", c, 7);
    chk("midrst pc before", pc, 16'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst state", current_state, S_HLT);
    chk("midrst instr0", instr0, 32'h0);
    chk("midrst instr1", instr1, 32'h0);
    chk("midrst pc", pc, 16'h0);
    chk("midrst addr", pmem_addr, 16'h0);
    reset = 1'b0; run = 1'b0;
    clear_prog();
    mem[4] = {O_CND, 24'h0}; mem[5] = {O_LB, 24'h7}; mem[6] = 32'hCAFEF00D; mem[7] = {O_END, 24'h0};
    s_cv[4] = 32'h0;
    run_prog("cnd_skip");
    chk("cnd_skip halt pc", pc, 16'h7);
    s_cv[4] = 32'h1;
    run_prog("cnd_noskip");
    chk("cnd_noskip halt pc", pc, 16'h7);
    clear_prog();
    mem[2] = {O_CND, 24'h0}; mem[3] = {O_CND, 24'h0}; mem[4] = {O_END, 24'h0}; mem[5] = {O_END, 24'h0};
    s_cv[2] = 32'h2;
    run_prog("cnd_chain");
    chk("cnd_chain halt pc", pc, 16'h4);
    clear_prog();
    s_j[0] = 1'b1; s_ja[0] = 16'hFFFF;
    mem[1] = {O_END, 24'h0};
    run_prog("wrap");
    chk("wrap halt pc", pc, 16'h1);
    clear_prog();
    s_mmu[9] = 1'b1;
    run_prog("mmu");
    chk("mmu pc", pc, 16'h9);
    chk("mmu fault", fault, 1'b1);
    chk("mmu stays halted", halted, 1'b1);
    do_reset();
    chk("mmu fault cleared by reset", fault, 1'b0);
    for (int t = 0; t < 25; t++) begin
      rand_prog();
      run_prog($sformatf("rnd%0d", t));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
- Instruction fetch and sequencing controller, directly upstream of the datapath.
- Reads 32-bit words from a synchronous program memory and assembles one- or two-word instructions into instr0/instr1.
- Drives current_state so the datapath acts only in STATE_EXEC.
- Updates the PC for sequential flow, jumps, conditional skip (CND), halt (END) and MMU fault.

Parameters:
- PC_W, 16, width of word-addressed PC and program memory address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  level; leave STATE_HLT and start fetching when high.
- pmem_addr  out  PC_W  program memory read address.
- pmem_rdata  in  32  read data, valid exactly 1 cycle after pmem_addr is presented.
- instr0  out  32  first word of current instruction.
- instr1  out  32  second word; 0 for one-word instructions.
- current_state  out  4  state code, using the `STATE_* encodings in def.v.
- pc  out  PC_W  address of instr0 of the current instruction.
- jump_req  in  1  sampled only in STATE_EXEC; jump to jump_addr.
- jump_addr  in  PC_W  jump target.
- cnd_val  in  32  register value read by the datapath for CND.
- mmu_invalid  in  1  sampled only in STATE_EXEC; fault.
- halted  out  1  high in STATE_HLT.
- fault  out  1  sticky; set by a fault, cleared only by reset.

Behaviour:
- Reset values: state=HLT, pc=RESET_PC, instr0=0, instr1=0, pmem_addr=RESET_PC, fault=0, skip flag=0.
- States (4-bit): HLT, FETCH0, FETCH0_W, FETCH1, FETCH1_W, EXEC.
- HLT: stay while run=0 or fault=1. Otherwise go to FETCH0.
- FETCH0: pmem_addr=pc. Go to FETCH0_W.
- FETCH0_W: latch pmem_rdata into instr0 and clear instr1.
  - Two-word op (op = pmem_rdata[31:24] is `OP_LIMM32 or `OP_LBSET): go to FETCH1.
  - Otherwise: go to EXEC.
- FETCH1: pmem_addr=pc+1. Go to FETCH1_W.
- FETCH1_W: latch pmem_rdata into instr1. Go to EXEC.
- Skip handling: if the skip flag is set when an instruction has been fully fetched (FETCH0_W for one-word ops, FETCH1_W for two-word ops):
  - clear the flag;
  - advance pc by the instruction length;
  - go to FETCH0 without entering EXEC. The datapath never sees EXEC for a skipped instruction.
- EXEC: exactly 1 cycle. Priority, highest first:
  1. mmu_invalid=1: fault<=1, state=HLT, pc unchanged.
  2. op=`OP_END: state=HLT, pc unchanged.
  3. jump_req=1: pc<=jump_addr, state=FETCH0.
  4. op=`OP_CND and cnd_val[0]==0: skip flag<=1, pc<=pc+len, state=FETCH0.
  5. Otherwise: pc<=pc+len, state=FETCH0.
- len: 2 for two-word ops, else 1. PC arithmetic is modulo 2^PC_W; wrap from all-ones to 0 is silent.
- CND followed by CND: the skipped CND is not executed, so it cannot chain-skip.
- A jump targeting the currently skipped path is impossible, because a skipped instruction never reaches EXEC.
- pmem_addr in states other than FETCH0/FETCH1 holds its last value.
- Cycles per instruction: 3 for one-word, 5 for two-word instructions.
- run is ignored outside HLT. Deasserting run does not stop an executing program; only END or a fault does.
- Restart from HLT after END: resumes at pc, i.e. re-executes END. Software restarts via reset.
- Reset mid-instruction: discard all partial fetch state and return to reset values on the next edge.

Test Plan:
- Reset, run=1, mem[0]=`OP_LIMM16 word, mem[1]=`OP_END:
  - state sequence FETCH0, FETCH0_W, EXEC, FETCH0, FETCH0_W, EXEC, HLT;
  - pc 0→1; halted=1.
- mem[0]=`OP_LIMM32 word, mem[1]=32'hDEADBEEF, mem[2]=END:
  - in EXEC, instr1=32'hDEADBEEF;
  - EXEC starts in the 5th cycle after run;
  - next pc=2.
- CND with cnd_val=0 at pc=4, mem[5]=LBSET (two-word):
  - LBSET never in EXEC;
  - next EXEC pc=7.
- CND with cnd_val=1 at pc=4: next EXEC pc=5.
- jump_req=1, jump_addr=16'h0100 in EXEC at pc=3: next FETCH0 pmem_addr=16'h0100.
- Jump with jump_addr=16'hFFFF, one-word non-jump op there: next pc=0 (wrap).
- mmu_invalid=1 in EXEC at pc=9:
  - HLT, fault=1, pc=9;
  - run=1 does not restart until reset.
- Reset asserted in FETCH1_W: next cycle state=HLT, instr0=instr1=0, pc=RESET_PC.
